// File: rtl/ethernet_pkg.sv
// Shared Ethernet receive definitions: address constants, filter FSM states, AXIS beat record.
// Pure declarations, no latency and no flow control of its own.
// Hold entries are sized for the widest legal stream (64 bit) and zero-extended when narrower.
package ethernet_pkg;

    localparam int eth_addr_width_gp = 48;
    localparam logic [eth_addr_width_gp-1:0] eth_broadcast_addr_gp = '1;

    localparam int eth_axis_max_data_width_gp = 64;
    localparam int eth_axis_max_keep_width_gp = eth_axis_max_data_width_gp / 8;

    typedef enum logic [1:0] {
        eth_rx_filter_header_e,
        eth_rx_filter_replay_e,
        eth_rx_filter_pass_e,
        eth_rx_filter_drop_e
    } eth_rx_filter_state_e;

    typedef struct packed {
        logic [eth_axis_max_data_width_gp-1:0] data;
        logic [eth_axis_max_keep_width_gp-1:0] keep;
        logic                                  last;
        logic                                  user;
    } eth_axis_beat_s;

    // Number of beats needed to see the whole destination address.
    function automatic int eth_rx_hdr_beats(input int data_width);
        return (eth_addr_width_gp + data_width - 1) / data_width;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Wrapping up-counter with synchronous clear.
// Count updates on the edge where up_i is sampled high; no backpressure.
// Clear and up together load init_val_p plus one.
module bsg_counter_clear_up #(
    parameter int                 width_p    = 16,
    parameter logic [width_p-1:0] init_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= init_val_p;
        end else if (clear_i) begin
            count_o <= init_val_p + width_p'(up_i);
        end else if (up_i) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/ethernet_rx_addr_match.sv
// Combinational destination-address compare: station, broadcast and, when
// ETHERNET_RX_FILTER_MULTICAST_EN is defined, any group address.
// Zero latency; no flow control.
module ethernet_rx_addr_match
    import ethernet_pkg::*;
(
    input  logic [eth_addr_width_gp-1:0] da_i,
    input  logic [eth_addr_width_gp-1:0] station_addr_i,
    output logic                         match_o
);

    logic station_hit;
    logic broadcast_hit;
    logic multicast_hit;

    assign station_hit   = (da_i == station_addr_i);
    assign broadcast_hit = (da_i == eth_broadcast_addr_gp);

`ifdef ETHERNET_RX_FILTER_MULTICAST_EN
    // Group bit is bit 0 of the first address byte on the wire.
    assign multicast_hit = da_i[0];
`else
    assign multicast_hit = 1'b0;
`endif

    assign match_o = station_hit | broadcast_hit | multicast_hit;

endmodule

// File: rtl/ethernet_rx_addr_filter.sv
// Destination-MAC filter on the receive AXIS; multicast acceptance via ETHERNET_RX_FILTER_MULTICAST_EN.
// Latency: first beat out one cycle after the decision beat, then zero per beat (hdr_beats bubbles/frame).
// Backpressure: stalls upstream while replaying held header beats, then passes tready straight through.
module ethernet_rx_addr_filter
    import ethernet_pkg::*;
#(
    parameter int data_width_p  = 32,
    parameter int count_width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [47:0]                mac_addr_i,
    input  logic                       promisc_i,
    input  logic [data_width_p-1:0]    mac_axis_tdata_i,
    input  logic [data_width_p/8-1:0]  mac_axis_tkeep_i,
    input  logic                       mac_axis_tvalid_i,
    output logic                       mac_axis_tready_o,
    input  logic                       mac_axis_tlast_i,
    input  logic                       mac_axis_tuser_i,
    output logic [data_width_p-1:0]    rx_axis_tdata_o,
    output logic [data_width_p/8-1:0]  rx_axis_tkeep_o,
    output logic                       rx_axis_tvalid_o,
    input  logic                       rx_axis_tready_i,
    output logic                       rx_axis_tlast_o,
    output logic                       rx_axis_tuser_o,
    output logic [count_width_p-1:0]   accept_count_o,
    output logic [count_width_p-1:0]   drop_count_o
);

    localparam int   keep_width_lp   = data_width_p / 8;
    localparam int   hdr_beats_lp    = eth_rx_hdr_beats(data_width_p);
    localparam logic hdr_last_idx_lp = 1'(hdr_beats_lp - 1);

    eth_rx_filter_state_e state_r, state_n;
    logic                 idx_r, idx_n;
    eth_axis_beat_s       hold_r [2];
    eth_axis_beat_s       beat_in;
    eth_axis_beat_s       beat_out;
    logic                 hold_we;

    logic [eth_addr_width_gp-1:0] da;
    logic                         addr_match;
    logic                         frame_match;
    logic                         accept_inc;
    logic                         drop_inc;
    logic                         unused_beat_bits;

    always_comb begin
        beat_in                          = '0;
        beat_in.data[data_width_p-1:0]   = mac_axis_tdata_i;
        beat_in.keep[keep_width_lp-1:0]  = mac_axis_tkeep_i;
        beat_in.last                     = mac_axis_tlast_i;
        beat_in.user                     = mac_axis_tuser_i;
    end

    // The decision beat is still on the input, so the address straddles it and hold[0].
    always_comb begin
        if (hdr_beats_lp == 1) begin
            da = beat_in.data[47:0];
        end else begin
            da = {beat_in.data[15:0], hold_r[0].data[31:0]};
        end
    end

    ethernet_rx_addr_match u_match (
        .da_i           (da),
        .station_addr_i (mac_addr_i),
        .match_o        (addr_match)
    );

    assign frame_match = promisc_i | addr_match;
    assign beat_out    = hold_r[idx_r];

    // Upper lanes of a hold entry carry nothing on a 32-bit stream.
    assign unused_beat_bits = ^beat_out;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eth_rx_filter_header_e;
            idx_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_r <= '{default: '0};
        end else if (hold_we) begin
            hold_r[idx_r] <= beat_in;
        end
    end

    always_comb begin
        state_n           = state_r;
        idx_n             = idx_r;
        hold_we           = 1'b0;
        accept_inc        = 1'b0;
        drop_inc          = 1'b0;
        mac_axis_tready_o = 1'b0;
        rx_axis_tdata_o   = '0;
        rx_axis_tkeep_o   = '0;
        rx_axis_tvalid_o  = 1'b0;
        rx_axis_tlast_o   = 1'b0;
        rx_axis_tuser_o   = 1'b0;

        case (state_r)
            eth_rx_filter_header_e: begin
                mac_axis_tready_o = 1'b1;
                if (mac_axis_tvalid_i) begin
                    hold_we = 1'b1;
                    if (idx_r != hdr_last_idx_lp) begin
                        if (mac_axis_tlast_i) begin
                            drop_inc = 1'b1;
                            idx_n    = 1'b0;
                        end else begin
                            idx_n = idx_r + 1'b1;
                        end
                    end else begin
                        idx_n = 1'b0;
                        if (frame_match) begin
                            state_n = eth_rx_filter_replay_e;
                        end else begin
                            drop_inc = 1'b1;
                            if (!mac_axis_tlast_i) begin
                                state_n = eth_rx_filter_drop_e;
                            end
                        end
                    end
                end
            end

            eth_rx_filter_replay_e: begin
                rx_axis_tvalid_o = 1'b1;
                rx_axis_tdata_o  = beat_out.data[data_width_p-1:0];
                rx_axis_tkeep_o  = beat_out.keep[keep_width_lp-1:0];
                rx_axis_tlast_o  = beat_out.last;
                rx_axis_tuser_o  = beat_out.user;
                if (rx_axis_tready_i) begin
                    if (idx_r == hdr_last_idx_lp) begin
                        idx_n = 1'b0;
                        if (beat_out.last) begin
                            state_n    = eth_rx_filter_header_e;
                            accept_inc = 1'b1;
                        end else begin
                            state_n = eth_rx_filter_pass_e;
                        end
                    end else begin
                        idx_n = idx_r + 1'b1;
                    end
                end
            end

            eth_rx_filter_pass_e: begin
                mac_axis_tready_o = rx_axis_tready_i;
                rx_axis_tvalid_o  = mac_axis_tvalid_i;
                rx_axis_tdata_o   = mac_axis_tdata_i;
                rx_axis_tkeep_o   = mac_axis_tkeep_i;
                rx_axis_tlast_o   = mac_axis_tlast_i;
                rx_axis_tuser_o   = mac_axis_tuser_i;
                if (mac_axis_tvalid_i && rx_axis_tready_i && mac_axis_tlast_i) begin
                    state_n    = eth_rx_filter_header_e;
                    accept_inc = 1'b1;
                end
            end

            eth_rx_filter_drop_e: begin
                mac_axis_tready_o = 1'b1;
                if (mac_axis_tvalid_i && mac_axis_tlast_i) begin
                    state_n = eth_rx_filter_header_e;
                end
            end

            default: begin
                state_n = eth_rx_filter_header_e;
                idx_n   = 1'b0;
            end
        endcase
    end

    bsg_counter_clear_up #(
        .width_p    (count_width_p),
        .init_val_p ('0)
    ) u_accept_count (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (1'b0),
        .up_i    (accept_inc),
        .count_o (accept_count_o)
    );

    bsg_counter_clear_up #(
        .width_p    (count_width_p),
        .init_val_p ('0)
    ) u_drop_count (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (1'b0),
        .up_i    (drop_inc),
        .count_o (drop_count_o)
    );

endmodule

// File: tb/tb_ethernet_rx_addr_filter.sv
// Randomized bench for ethernet_rx_addr_filter: frame-level accept model plus beat scoreboard.
module tb_ethernet_rx_addr_filter;

    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int CW  = 16;
    localparam int HDR = (DW == 64) ? 1 : 2;
`ifdef ETHERNET_RX_FILTER_MULTICAST_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [47:0]   station = '0;
    logic          promisc = 1'b0;
    logic [DW-1:0] mac_tdata = '0;
    logic [KW-1:0] mac_tkeep = '0;
    logic          mac_tvalid = 1'b0;
    logic          mac_tready;
    logic          mac_tlast = 1'b0;
    logic          mac_tuser = 1'b0;
    logic [DW-1:0] rx_tdata;
    logic [KW-1:0] rx_tkeep;
    logic          rx_tvalid;
    logic          rx_tready = 1'b1;
    logic          rx_tlast;
    logic          rx_tuser;
    logic [CW-1:0] accept_count;
    logic [CW-1:0] drop_count;

    ethernet_rx_addr_filter #(.data_width_p(DW), .count_width_p(CW)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .mac_addr_i        (station),
        .promisc_i         (promisc),
        .mac_axis_tdata_i  (mac_tdata),
        .mac_axis_tkeep_i  (mac_tkeep),
        .mac_axis_tvalid_i (mac_tvalid),
        .mac_axis_tready_o (mac_tready),
        .mac_axis_tlast_i  (mac_tlast),
        .mac_axis_tuser_i  (mac_tuser),
        .rx_axis_tdata_o   (rx_tdata),
        .rx_axis_tkeep_o   (rx_tkeep),
        .rx_axis_tvalid_o  (rx_tvalid),
        .rx_axis_tready_i  (rx_tready),
        .rx_axis_tlast_o   (rx_tlast),
        .rx_axis_tuser_o   (rx_tuser),
        .accept_count_o    (accept_count),
        .drop_count_o      (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    exp_acc = 0;
    int    exp_drop = 0;
    int    exp_beats = 0;
    int    cyc = 0;
    int    dn_count = 0;
    int    first_dn_cyc = 0;
    int    last_dn_cyc = 0;
    int    first_up_cyc = 0;
    int    up_stalls = 0;
    logic  last_dn_user = 1'b0;
    int    rdy_mode = 0;
    bit    prev_stall = 1'b0;
    beat_t held;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rx_tready = 1'b1;
            1:       rx_tready = ~rx_tready;
            default: rx_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Downstream monitor: scoreboard, stall stability, timing capture.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (rx_tvalid !== 1'b1 || rx_tdata !== held.data || rx_tkeep !== held.keep ||
                    rx_tlast !== held.last || rx_tuser !== held.user) begin
                    errors++;
                    $display("FAIL stall_hold got vld=%b data=%h keep=%h want data=%h keep=%h",
                             rx_tvalid, rx_tdata, rx_tkeep, held.data, held.keep);
                end
            end
            prev_stall = rx_tvalid && !rx_tready;
            held = '{rx_tdata, rx_tkeep, rx_tlast, rx_tuser};
            if (rx_tvalid && rx_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got data=%h keep=%h last=%b, want none",
                             rx_tdata, rx_tkeep, rx_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_tdata !== e.data || rx_tkeep !== e.keep || rx_tlast !== e.last || rx_tuser !== e.user) begin
                        errors++;
                        $display("FAIL dn_beat got data=%h keep=%h last=%b user=%b want data=%h keep=%h last=%b user=%b",
                                 rx_tdata, rx_tkeep, rx_tlast, rx_tuser, e.data, e.keep, e.last, e.user);
                    end
                end
                if (dn_count == 0) first_dn_cyc = cyc;
                last_dn_cyc  = cyc;
                last_dn_user = rx_tuser;
                dn_count++;
            end
            if (mac_tvalid && !mac_tready) up_stalls++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] mac(input logic [7:0] b0, b1, b2, b3, b4, b5);
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic send_beat(input beat_t b, output int acc_cyc);
        int n = 0;
        mac_tdata  = b.data;
        mac_tkeep  = b.keep;
        mac_tlast  = b.last;
        mac_tuser  = b.user;
        mac_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (mac_tready) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL upstream_timeout ready=%b want 1", mac_tready);
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        mac_tvalid = 1'b0;
    endtask

    // Builds a frame, decides its fate from the filter rules, queues expected beats, sends it.
    task automatic run_frame(input logic [47:0] da, input int len, input logic user,
                             input int gap_max, input bit scramble, input int max_beats);
        logic [7:0]  fb[$];
        beat_t       beats[$];
        int          nb, c;
        bit          da_hit, bc, grp, acc;
        logic [47:0] save_station;
        logic        save_promisc;
        for (int i = 0; i < 6; i++) fb.push_back(da[8*i +: 8]);
        while (fb.size() < len) fb.push_back(8'($urandom));
        while (fb.size() > len) void'(fb.pop_back());
        nb = (len + KW - 1) / KW;
        da_hit = 1'b1;
        bc     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (fb[i] != station[8*i +: 8]) da_hit = 1'b0;
            if (fb[i] != 8'hFF) bc = 1'b0;
        end
        grp = MC && fb[0][0];
        acc = (nb >= HDR) && (promisc || da_hit || bc || grp);
        if (acc) exp_acc++; else exp_drop++;
        for (int k = 0; k < nb; k++) begin
            beat_t b;
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < KW; j++) begin
                if (k*KW + j < len) begin
                    b.data[8*j +: 8] = fb[k*KW + j];
                    b.keep[j] = 1'b1;
                end else begin
                    b.data[8*j +: 8] = 8'($urandom);
                end
            end
            b.last = (k == nb - 1);
            b.user = b.last ? user : 1'b0;
            beats.push_back(b);
            if (acc) begin
                exp_q.push_back(b);
                exp_beats++;
            end
        end
        save_station = station;
        save_promisc = promisc;
        for (int k = 0; k < nb && k < max_beats; k++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            send_beat(beats[k], c);
            if (k == 0) first_up_cyc = c;
            if (scramble && k == HDR - 1) begin
                station = {16'($urandom), $urandom};
                promisc = 1'($urandom_range(0, 1));
            end
        end
        station = save_station;
        promisc = save_promisc;
    endtask

    task automatic wait_flush();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (accept_count !== CW'(exp_acc)) begin
            errors++;
            $display("FAIL %s accept_count got %0d want %0d", name, accept_count, exp_acc);
        end
        checks++;
        if (drop_count !== CW'(exp_drop)) begin
            errors++;
            $display("FAIL %s drop_count got %0d want %0d", name, drop_count, exp_drop);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_tvalid !== 1'b0 || rx_tdata !== '0 || rx_tkeep !== '0 || rx_tlast !== 1'b0 || rx_tuser !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_outputs got vld=%b data=%h keep=%h last=%b user=%b want all 0",
                     rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser);
        end
        checks++;
        if (mac_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready got %b want 1", mac_tready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_counts("reset");
    endtask

    task automatic test_station_frame();
        station = mac(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        promisc = 1'b0;
        rdy_mode = 0;
        @(posedge clk); #1;
        dn_count = 0;
        up_stalls = 0;
        run_frame(station, 64, 1'b0, 0, 0, 1000);
        wait_flush();
        checks++;
        if (dn_count != 64 / KW) begin
            errors++;
            $display("FAIL station_beats got %0d want %0d", dn_count, 64 / KW);
        end
        checks++;
        if (first_dn_cyc - first_up_cyc != HDR) begin
            errors++;
            $display("FAIL station_latency got %0d want %0d", first_dn_cyc - first_up_cyc, HDR);
        end
        checks++;
        if (last_dn_cyc - first_up_cyc != 64 / KW - 1 + HDR) begin
            errors++;
            $display("FAIL station_duration got %0d want %0d", last_dn_cyc - first_up_cyc, 64 / KW - 1 + HDR);
        end
        checks++;
        if (up_stalls != HDR) begin
            errors++;
            $display("FAIL station_bubbles got %0d want %0d", up_stalls, HDR);
        end
        check_counts("station");
    endtask

    task automatic test_drop_unicast();
        dn_count = 0;
        up_stalls = 0;
        run_frame(mac(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02), 64, 1'b0, 0, 0, 1000);
        wait_flush();
        checks++;
        if (dn_count != 0 || up_stalls != 0) begin
            errors++;
            $display("FAIL drop_unicast got beats=%0d stalls=%0d want 0 and 0", dn_count, up_stalls);
        end
        check_counts("drop_unicast");
    endtask

    task automatic test_broadcast_stall();
        rdy_mode = 1;
        dn_count = 0;
        run_frame(48'hFFFF_FFFF_FFFF, 40, 1'b0, 0, 0, 1000);
        wait_flush();
        checks++;
        if (dn_count != 40 / KW) begin
            errors++;
            $display("FAIL broadcast_beats got %0d want %0d", dn_count, 40 / KW);
        end
        rdy_mode = 0;
        check_counts("broadcast");
    endtask

    task automatic test_multicast();
        logic [47:0] grp_da;
        grp_da = mac(8'h01, 8'h00, 8'h5E, 8'h00, 8'h00, 8'h01);
        dn_count = 0;
        promisc = 1'b0;
        run_frame(grp_da, 64, 1'b0, 1, 0, 1000);
        wait_flush();
        checks++;
        if (dn_count != (MC ? 64 / KW : 0)) begin
            errors++;
            $display("FAIL multicast_nopromisc beats got %0d want %0d", dn_count, MC ? 64 / KW : 0);
        end
        dn_count = 0;
        promisc = 1'b1;
        run_frame(grp_da, 64, 1'b0, 1, 0, 1000);
        wait_flush();
        promisc = 1'b0;
        checks++;
        if (dn_count != 64 / KW) begin
            errors++;
            $display("FAIL multicast_promisc beats got %0d want %0d", dn_count, 64 / KW);
        end
        check_counts("multicast");
    endtask

    task automatic test_runt();
        int drop0;
        drop0 = exp_drop;
        dn_count = 0;
        run_frame(station, 3, 1'b0, 0, 0, 1000);
        run_frame(station, 24, 1'b0, 0, 0, 1000);
        wait_flush();
        checks++;
        if (HDR > 1 && drop_count !== CW'(drop0 + 1)) begin
            errors++;
            $display("FAIL runt_drop got %0d want %0d", drop_count, drop0 + 1);
        end
        checks++;
        if (dn_count != 24 / KW) begin
            errors++;
            $display("FAIL runt_follow beats got %0d want %0d", dn_count, 24 / KW);
        end
        check_counts("runt");
    endtask

    task automatic test_tuser();
        dn_count = 0;
        run_frame(station, 30, 1'b1, 0, 0, 1000);
        wait_flush();
        checks++;
        if (last_dn_user !== 1'b1 || dn_count != (30 + KW - 1) / KW) begin
            errors++;
            $display("FAIL tuser_last got user=%b beats=%0d want 1 and %0d", last_dn_user, dn_count, (30 + KW - 1) / KW);
        end
        check_counts("tuser");
    endtask

    task automatic test_back_to_back();
        int beats0;
        rdy_mode = 2;
        dn_count = 0;
        beats0 = exp_beats;
        for (int f = 0; f < 50; f++) begin
            logic [47:0] da;
            int          kind, len;
            kind = $urandom_range(0, 4);
            case (kind)
                0:       da = station;
                1:       da = 48'hFFFF_FFFF_FFFF;
                2:       da = mac(8'h01, 8'h00, 8'h5E, 8'($urandom), 8'($urandom), 8'($urandom));
                3:       da = {16'($urandom), $urandom} & ~48'h1;
                default: da = {16'($urandom), $urandom};
            endcase
            promisc = ($urandom_range(0, 5) == 0);
            if (HDR > 1 && $urandom_range(0, 7) == 0) len = $urandom_range(1, (HDR - 1) * KW);
            else len = $urandom_range(8, 48);
            run_frame(da, len, 1'($urandom_range(0, 1)), 2, 1, 1000);
        end
        promisc = 1'b0;
        wait_flush();
        rdy_mode = 0;
        checks++;
        if (dn_count != exp_beats - beats0) begin
            errors++;
            $display("FAIL random_beats got %0d want %0d", dn_count, exp_beats - beats0);
        end
        check_counts("random");
    endtask

    task automatic test_reset_midframe();
        run_frame(station, 40, 1'b0, 0, 0, 5);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_tvalid !== 1'b0 || mac_tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs got vld=%b rdy=%b want 0 and 1", rx_tvalid, mac_tready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_acc = 0;
        exp_drop = 0;
        check_counts("midreset_cleared");
        dn_count = 0;
        run_frame(station, 20, 1'b0, 0, 0, 1000);
        wait_flush();
        checks++;
        if (dn_count != 20 / KW) begin
            errors++;
            $display("FAIL midreset_next beats got %0d want %0d", dn_count, 20 / KW);
        end
        check_counts("midreset_next");
    endtask

    initial begin
        test_reset();
        test_station_frame();
        test_drop_unicast();
        test_broadcast_stall();
        test_multicast();
        test_runt();
        test_tuser();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
